mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store stage directly downstream of the ALU. Takes the ALU result as the
//  effective address and rt as store data, then runs one access on a
//  valid/ack memory bus. Holds the core (stall) until the access completes.
//  Returns byte/half/word load data extended to 32 bits for register write-back.
//  Flags misaligned accesses and bus timeouts.
// PARAMETERS
//  BIG_ENDIAN      0    0: byte k of a word is bits [8k+7:8k]; 1: lane index k -> 3-k
//  TIMEOUT_CYCLES  255  max REQ cycles without ack before bus_err; 0 disables timeout
//  TO_W            8    width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous reset, active-high
//  op_valid   in   1   current instruction is a load/store
//  mem_op     in   3   `MEMOP_LW/LH/LHU/LB/LBU/SW/SH/SB
//  addr       in   32  effective address (ALU result c)
//  wdata      in   32  store data (rt)
//  stall      out  1   hold PC and suppress write-back this cycle
//  done       out  1   1-cycle pulse: access finished, rdata/flags valid
//  rdata      out  32  load result, extended; 0 for stores and errors
//  addr_err   out  1   misaligned access (valid with done)
//  bus_err    out  1   timeout (valid with done)
//  bus_req    out  1   request, held until ack or timeout
//  bus_we     out  1   1 = write
//  bus_addr   out  32  {addr[31:2],2'b00}
//  bus_be     out  4   byte enables
//  bus_wdata  out  32  lane-replicated store data
//  bus_ack    in   1   slave completes the access this cycle
//  bus_rdata  in   32  read word, valid with bus_ack
// BEHAVIOUR
//  - Reset: state IDLE. All registered outputs are 0. stall=0 while rst is high.
//  - FSM IDLE -> REQ -> DONE -> IDLE.
//  - IDLE, op_valid=1, aligned: latch op, addr, be and wdata; go to REQ.
//  - IDLE, op_valid=1, misaligned: no bus cycle; go to DONE with addr_err=1.
//    Misaligned means LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
//  - REQ: bus_req=1 with bus_we/addr/be/wdata stable. On bus_ack, capture the
//    formatted rdata and go to DONE.
//  - REQ timeout: when the counter reaches TIMEOUT_CYCLES, drop bus_req, go to
//    DONE with bus_err=1 and rdata=0.
//  - DONE: done=1, stall=0. The core commits at this edge. Next state is IDLE.
//    op_valid is ignored in DONE.
//  - stall = (IDLE & op_valid & !rst) | REQ. It is combinational.
//  - Latency: with ack on the first REQ cycle, 3 cycles (IDLE, REQ, DONE).
//    stall is high for 2 of them. Each extra wait cycle adds one.
//  - Byte enables (LE): byte 4'b0001<<a[1:0]; half a[1]?4'b1100:4'b0011; word 4'b1111.
//  - bus_wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
//  - Loads select the addressed lane. LB/LH sign-extend; LBU/LHU zero-extend.
//  - BIG_ENDIAN=1 mirrors the lane index for both be and load selection.
//  - bus_ack outside REQ is ignored, e.g. a late ack after a timeout or reset.
//  - Reset mid-operation: at the rst edge, state returns to IDLE, bus_req drops
//    and no done pulse is produced.
//  - done, addr_err, bus_err and rdata hold their value only in the DONE cycle.
//    They return to 0 in IDLE.
// STRUCTURE
//  - The `MEMOP_* encodings go in ctrl_encode_def.v, shared with the controller.
//    LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
//  - State encodings are local localparams.
//  - Sub-module lsu_align: purely combinational. From op, addr[1:0] and
//    BIG_ENDIAN it produces be, misalign, replicated wdata and extended rdata.
//  - The top holds the FSM, the latches and the timeout counter.
// TESTING
//  1 SW addr=0x10 wdata=0xDEADBEEF, ack on 1st REQ -> bus_be=1111, we=1,
//    done at cycle 3, stall high for 2 cycles.
//  2 LB addr=0x13, bus_rdata=0x80FF7F01, LE -> rdata=0xFFFFFF80.
//    Same access as LBU -> rdata=0x00000080.
//  3 SH addr=0x22 wdata=0x1234ABCD -> bus_addr=0x20, be=1100,
//    bus_wdata=0xABCDABCD. With BIG_ENDIAN=1 -> be=0011.
//  4 LW addr=0x06 -> no bus_req, done with addr_err=1 and rdata=0 one cycle
//    after accept.
//  5 LW with no ack, TIMEOUT_CYCLES=4 -> bus_req high for 4 cycles, then done
//    with bus_err=1. An ack one cycle later is ignored.
//  6 rst asserted in the 2nd REQ cycle -> next cycle IDLE, bus_req=0, stall=0,
//    no done.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
//   Shared definitions for the load/store stage.
//   - MEMOP_* encodings of the 3-bit memory operation. The instruction
//     controller uses the same encodings.
//   - Access-size enum and small decode helpers, used by the alignment
//     logic so that the op encoding is decoded in one place only.
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

  localparam logic [2:0] MEMOP_LW  = 3'd0;
  localparam logic [2:0] MEMOP_LH  = 3'd1;
  localparam logic [2:0] MEMOP_LHU = 3'd2;
  localparam logic [2:0] MEMOP_LB  = 3'd3;
  localparam logic [2:0] MEMOP_LBU = 3'd4;
  localparam logic [2:0] MEMOP_SW  = 3'd5;
  localparam logic [2:0] MEMOP_SH  = 3'd6;
  localparam logic [2:0] MEMOP_SB  = 3'd7;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  function automatic size_e op_size(input logic [2:0] op);
    case (op)
      MEMOP_LW, MEMOP_SW:            op_size = SZ_WORD;
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: op_size = SZ_HALF;
      default:                       op_size = SZ_BYTE;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [2:0] op);
    op_is_store = (op == MEMOP_SW) || (op == MEMOP_SH) || (op == MEMOP_SB);
  endfunction

  // Only LB and LH sign-extend; LBU/LHU zero-extend, LW needs no extension.
  function automatic logic op_is_signed(input logic [2:0] op);
    op_is_signed = (op == MEMOP_LB) || (op == MEMOP_LH);
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Purely combinational lane logic for one memory access.
//   Ports:
//     i_op        memory operation (MEMOP_*)
//     i_lane      address bits [1:0] of the access
//     i_wdata     raw store data (rt)
//     i_rdata     word returned by the bus
//     o_be        byte enables for the bus
//     o_misalign  access is not naturally aligned for its size
//     o_wdata     store data replicated onto every lane it may land in
//     o_rdata     selected load lane, sign/zero extended to 32 bits
//   BIG_ENDIAN mirrors the lane index (k -> 3-k) for both enables and
//   load selection; replicated store data needs no mirroring.
// -----------------------------------------------------------------------------
module lsu_align
  import mem_access_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic        o_misalign,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  size_e       w_size;
  logic        w_signed;
  logic [1:0]  w_byte_lane;
  logic        w_hi_half;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_size      = op_size(i_op);
  assign w_signed    = op_is_signed(i_op);
  assign w_byte_lane = i_lane ^ {2{BIG_ENDIAN}};
  assign w_hi_half   = i_lane[1] ^ BIG_ENDIAN;
  assign w_byte      = i_rdata[{w_byte_lane, 3'b000} +: 8];
  assign w_half      = w_hi_half ? i_rdata[31:16] : i_rdata[15:0];

  // NOTE: every output gets a default before the case so no path can leave
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    o_be       = 4'b1111;
    o_misalign = 1'b0;
    o_wdata    = i_wdata;
    o_rdata    = i_rdata;
    case (w_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << w_byte_lane;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_signed & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be       = w_hi_half ? 4'b1100 : 4'b0011;
        o_misalign = i_lane[0];
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = {{16{w_signed & w_half[15]}}, w_half};
      end
      default: begin
        o_misalign = |i_lane;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store stage behind the ALU. Runs one valid/ack bus access per
//   load/store, stalls the core until it completes, and returns extended
//   load data plus misalignment / timeout flags with a one-cycle done pulse.
//   Ports:
//     clk, rst            clock; synchronous active-high reset
//     op_valid, mem_op    instruction is a load/store, and which one
//     addr, wdata         effective address (ALU result), store data (rt)
//     stall               hold PC / suppress write-back (combinational)
//     done                one-cycle completion pulse
//     rdata               extended load result (0 for stores and errors)
//     addr_err, bus_err   misaligned access / bus timeout, valid with done
//     bus_req/we/addr/be/wdata   request side of the memory bus
//     bus_ack, bus_rdata         response side of the memory bus
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int BIG_ENDIAN     = 0,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic            TO_EN   = (TIMEOUT_CYCLES != 0);
  // Counter value seen in the last permitted REQ cycle (counter starts at 0).
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e r_state;
  state_e w_next_state;

  logic [2:0]      r_op;
  logic [1:0]      r_lane;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [3:0]      r_be;
  logic [31:0]     r_wdata;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_done;
  logic            r_addr_err;
  logic            r_bus_err;
  logic [31:0]     r_rdata;

  logic            w_idle;
  logic [2:0]      w_sel_op;
  logic [1:0]      w_sel_lane;
  logic [3:0]      w_be;
  logic            w_misalign;
  logic [31:0]     w_wdata;
  logic [31:0]     w_fmt_rdata;
  logic            w_timeout;
  logic            w_stall;
  logic            w_bus_req;

  // In IDLE the aligner decodes the incoming op; afterwards it works on the
  // latched op so load formatting sees the access that is actually in flight.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_sel_op   = w_idle ? mem_op : r_op;
  assign w_sel_lane = w_idle ? addr[1:0] : r_lane;
  assign w_timeout  = TO_EN && (r_to_cnt == TO_LAST);

  lsu_align #(
    .BIG_ENDIAN (BIG_ENDIAN != 0)
  ) u_align (
    .i_op       (w_sel_op),
    .i_lane     (w_sel_lane),
    .i_wdata    (wdata),
    .i_rdata    (bus_rdata),
    .o_be       (w_be),
    .o_misalign (w_misalign),
    .o_wdata    (w_wdata),
    .o_rdata    (w_fmt_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_bus_req    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (op_valid) begin
          w_stall      = !rst;
          w_next_state = w_misalign ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        w_stall   = 1'b1;
        w_bus_req = 1'b1;
        if (bus_ack || w_timeout) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Access latches, timeout counter and the DONE-cycle result registers.
  // Result registers default to 0 each cycle so they are only non-zero
  // during the single DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= MEMOP_LW;
      r_lane     <= 2'b00;
      r_we       <= 1'b0;
      r_addr     <= 32'h0;
      r_be       <= 4'h0;
      r_wdata    <= 32'h0;
      r_to_cnt   <= '0;
      r_done     <= 1'b0;
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
      r_rdata    <= 32'h0;
    end else begin
      r_done     <= 1'b0;
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
      r_rdata    <= 32'h0;
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            if (w_misalign) begin
              r_done     <= 1'b1;
              r_addr_err <= 1'b1;
            end else begin
              r_op     <= mem_op;
              r_lane   <= addr[1:0];
              r_we     <= op_is_store(mem_op);
              r_addr   <= {addr[31:2], 2'b00};
              r_be     <= w_be;
              r_wdata  <= w_wdata;
              r_to_cnt <= '0;
            end
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            r_done  <= 1'b1;
            r_rdata <= r_we ? 32'h0 : w_fmt_rdata;
          end else if (w_timeout) begin
            r_done    <= 1'b1;
            r_bus_err <= 1'b1;
          end else if (TO_EN) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign stall     = w_stall;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign addr_err  = r_addr_err;
  assign bus_err   = r_bus_err;
  assign bus_req   = w_bus_req;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_be    = r_be;
  assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed bench for the load/store stage. Two instances share all inputs:
//   one little-endian, one big-endian, both with a 4-cycle bus timeout.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic        le_stall, le_done, le_addr_err, le_bus_err, le_bus_req, le_bus_we;
  logic [31:0] le_rdata, le_bus_addr, le_bus_wdata;
  logic [3:0]  le_bus_be;
  logic        be_stall, be_done, be_addr_err, be_bus_err, be_bus_req, be_bus_we;
  logic [31:0] be_rdata, be_bus_addr, be_bus_wdata;
  logic [3:0]  be_bus_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.BIG_ENDIAN(0), .TIMEOUT_CYCLES(4), .TO_W(8)) dut_le (
    .clk(clk), .rst(rst), .op_valid(op_valid), .mem_op(mem_op), .addr(addr),
    .wdata(wdata), .stall(le_stall), .done(le_done), .rdata(le_rdata),
    .addr_err(le_addr_err), .bus_err(le_bus_err), .bus_req(le_bus_req),
    .bus_we(le_bus_we), .bus_addr(le_bus_addr), .bus_be(le_bus_be),
    .bus_wdata(le_bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  mem_access_unit #(.BIG_ENDIAN(1), .TIMEOUT_CYCLES(4), .TO_W(8)) dut_be (
    .clk(clk), .rst(rst), .op_valid(op_valid), .mem_op(mem_op), .addr(addr),
    .wdata(wdata), .stall(be_stall), .done(be_done), .rdata(be_rdata),
    .addr_err(be_addr_err), .bus_err(be_bus_err), .bus_req(be_bus_req),
    .bus_we(be_bus_we), .bus_addr(be_bus_addr), .bus_be(be_bus_be),
    .bus_wdata(be_bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // Drive a new op in an IDLE cycle (inputs change on the falling edge).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    op_valid = 1'b1; mem_op = op; addr = a; wdata = wd;
    #1;
  endtask

  // One complete access with ack on the first REQ cycle; returns observations.
  task automatic run_access(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd,
                            output logic [3:0] o_le_be, output logic [3:0] o_be_be,
                            output logic [31:0] o_addr, output logic [31:0] o_wdata,
                            output logic o_done, output logic [31:0] o_le_rd,
                            output logic [31:0] o_be_rd);
    issue(op, a, wd);
    @(negedge clk);
    op_valid = 1'b0; bus_ack = 1'b1; bus_rdata = rd;
    #1;
    o_le_be = le_bus_be; o_be_be = be_bus_be; o_addr = le_bus_addr; o_wdata = le_bus_wdata;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    o_done = le_done & be_done; o_le_rd = le_rdata; o_be_rd = be_rdata;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b1; mem_op = MEMOP_LW; addr = 32'h0; wdata = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (le_stall !== 1'b0 || be_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b/%b expected 0", le_stall, be_stall); end
    checks++; if ({le_done, le_bus_req, le_addr_err, le_bus_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {le_done, le_bus_req, le_addr_err, le_bus_err}); end
    checks++; if (le_rdata !== 32'h0 || le_bus_be !== 4'h0 || le_bus_addr !== 32'h0) begin errors++; $display("FAIL reset_regs: rdata %h be %h addr %h expected 0", le_rdata, le_bus_be, le_bus_addr); end
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (le_bus_req !== 1'b0 || le_done !== 1'b0) begin errors++; $display("FAIL reset_release: req %b done %b expected 0 0", le_bus_req, le_done); end
  endtask

  task automatic test_store_word();
    int stall_cnt = 0;
    issue(MEMOP_SW, 32'h10, 32'hDEADBEEF);
    if (le_stall) stall_cnt++;
    @(negedge clk);
    op_valid = 1'b0; bus_ack = 1'b1;
    #1;
    if (le_stall) stall_cnt++;
    checks++; if ({le_bus_req, le_bus_we, le_bus_be} !== 6'b11_1111) begin errors++; $display("FAIL sw_bus: req/we/be got %b expected 111111", {le_bus_req, le_bus_we, le_bus_be}); end
    checks++; if (le_bus_addr !== 32'h10 || le_bus_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_addr_data: got %h %h expected 00000010 deadbeef", le_bus_addr, le_bus_wdata); end
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    if (le_stall) stall_cnt++;
    checks++; if ({le_done, le_addr_err, le_bus_err, le_bus_req} !== 4'b1000) begin errors++; $display("FAIL sw_done_cycle3: done/aerr/berr/req got %b expected 1000", {le_done, le_addr_err, le_bus_err, le_bus_req}); end
    checks++; if (le_rdata !== 32'h0) begin errors++; $display("FAIL sw_rdata: got %h expected 0", le_rdata); end
    checks++; if (stall_cnt != 2) begin errors++; $display("FAIL sw_stall_cycles: got %0d expected 2", stall_cnt); end
    @(negedge clk);
    #1;
    checks++; if (le_done !== 1'b0 || le_stall !== 1'b0) begin errors++; $display("FAIL sw_back_idle: done %b stall %b expected 0 0", le_done, le_stall); end
  endtask

  task automatic test_loads();
    logic [3:0] lbe, bbe; logic [31:0] ad, wd, lrd, brd; logic dn;
    run_access(MEMOP_LB, 32'h13, 32'h0, 32'h80FF7F01, lbe, bbe, ad, wd, dn, lrd, brd);
    checks++; if (lbe !== 4'b1000 || bbe !== 4'b0001) begin errors++; $display("FAIL lb_be: got %b/%b expected 1000/0001", lbe, bbe); end
    checks++; if (dn !== 1'b1 || lrd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_le_rdata: done %b got %h expected ffffff80", dn, lrd); end
    checks++; if (brd !== 32'h00000001) begin errors++; $display("FAIL lb_be_rdata: got %h expected 00000001", brd); end
    run_access(MEMOP_LBU, 32'h13, 32'h0, 32'h80FF7F01, lbe, bbe, ad, wd, dn, lrd, brd);
    checks++; if (lrd !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata: got %h expected 00000080", lrd); end
    run_access(MEMOP_LH, 32'h22, 32'h0, 32'h80FF7F01, lbe, bbe, ad, wd, dn, lrd, brd);
    checks++; if (lrd !== 32'hFFFF80FF || brd !== 32'h00007F01) begin errors++; $display("FAIL lh_rdata: got %h/%h expected ffff80ff/00007f01", lrd, brd); end
    run_access(MEMOP_LHU, 32'h20, 32'h0, 32'h80FF8001, lbe, bbe, ad, wd, dn, lrd, brd);
    checks++; if (lrd !== 32'h00008001 || brd !== 32'h000080FF) begin errors++; $display("FAIL lhu_rdata: got %h/%h expected 00008001/000080ff", lrd, brd); end
    run_access(MEMOP_LW, 32'h44, 32'h0, 32'hCAFEF00D, lbe, bbe, ad, wd, dn, lrd, brd);
    checks++; if (lrd !== 32'hCAFEF00D || ad !== 32'h44) begin errors++; $display("FAIL lw_rdata: got %h addr %h expected cafef00d 00000044", lrd, ad); end
  endtask

  task automatic test_store_half();
    logic [3:0] lbe, bbe; logic [31:0] ad, wd, lrd, brd; logic dn;
    run_access(MEMOP_SH, 32'h22, 32'h1234ABCD, 32'h5555AAAA, lbe, bbe, ad, wd, dn, lrd, brd);
    checks++; if (ad !== 32'h20 || wd !== 32'hABCDABCD) begin errors++; $display("FAIL sh_addr_data: got %h %h expected 00000020 abcdabcd", ad, wd); end
    checks++; if (lbe !== 4'b1100 || bbe !== 4'b0011) begin errors++; $display("FAIL sh_be: got %b/%b expected 1100/0011", lbe, bbe); end
    checks++; if (dn !== 1'b1 || lrd !== 32'h0) begin errors++; $display("FAIL sh_done: done %b rdata %h expected 1 0", dn, lrd); end
  endtask

  task automatic test_misaligned();
    issue(MEMOP_LW, 32'h06, 32'h0);
    bus_rdata = 32'hFFFFFFFF;
    checks++; if (le_stall !== 1'b1) begin errors++; $display("FAIL mis_stall: got %b expected 1", le_stall); end
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    checks++; if ({le_done, le_addr_err, le_bus_err, le_bus_req} !== 4'b1100) begin errors++; $display("FAIL mis_done: done/aerr/berr/req got %b expected 1100", {le_done, le_addr_err, le_bus_err, le_bus_req}); end
    checks++; if (le_rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata: got %h expected 0", le_rdata); end
    @(negedge clk);
    #1;
    checks++; if (le_done !== 1'b0 || le_addr_err !== 1'b0 || le_bus_req !== 1'b0) begin errors++; $display("FAIL mis_after: done %b aerr %b req %b expected 0 0 0", le_done, le_addr_err, le_bus_req); end
    issue(MEMOP_SH, 32'h23, 32'h0);
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    checks++; if (le_addr_err !== 1'b1 || le_bus_req !== 1'b0) begin errors++; $display("FAIL mis_sh: aerr %b req %b expected 1 0", le_addr_err, le_bus_req); end
    bus_rdata = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    logic seen = 1'b0;
    issue(MEMOP_LW, 32'h40, 32'h0);
    bus_rdata = 32'h12345678;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      if (le_done) seen = 1'b1;
      else if (le_bus_req) req_cnt++;
    end
    checks++; if (!seen) begin errors++; $display("FAIL to_no_done: got no done in 10 cycles expected done"); end
    checks++; if (req_cnt != 4) begin errors++; $display("FAIL to_req_cycles: got %0d expected 4", req_cnt); end
    checks++; if ({le_bus_err, le_addr_err, le_bus_req} !== 3'b100 || le_rdata !== 32'h0) begin errors++; $display("FAIL to_flags: berr/aerr/req %b rdata %h expected 100 0", {le_bus_err, le_addr_err, le_bus_req}, le_rdata); end
    bus_ack = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (le_done !== 1'b0 || le_bus_req !== 1'b0 || le_rdata !== 32'h0) begin errors++; $display("FAIL to_late_ack: done %b req %b rdata %h expected 0 0 0", le_done, le_bus_req, le_rdata); end
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    checks++; if (le_done !== 1'b0 || le_stall !== 1'b0) begin errors++; $display("FAIL to_idle: done %b stall %b expected 0 0", le_done, le_stall); end
  endtask

  task automatic test_reset_mid_op();
    issue(MEMOP_LW, 32'h80, 32'h0);
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (le_bus_req !== 1'b1) begin errors++; $display("FAIL rst_mid_inreq: req got %b expected 1", le_bus_req); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({le_bus_req, le_stall, le_done} !== 3'b000) begin errors++; $display("FAIL rst_mid_after: req/stall/done got %b expected 000", {le_bus_req, le_stall, le_done}); end
    @(negedge clk);
    #1;
    checks++; if (le_done !== 1'b0 || be_done !== 1'b0) begin errors++; $display("FAIL rst_mid_nodone: got %b/%b expected 0", le_done, be_done); end
  endtask

  // op_valid held high throughout: ignored in DONE, accepted again in IDLE.
  task automatic test_back_to_back();
    issue(MEMOP_SB, 32'h01, 32'h000000A5);
    @(negedge clk);
    bus_ack = 1'b1;
    #1;
    checks++; if (le_bus_be !== 4'b0010 || be_bus_be !== 4'b0100 || le_bus_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_sb: be %b/%b wdata %h expected 0010/0100 a5a5a5a5", le_bus_be, be_bus_be, le_bus_wdata); end
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    checks++; if (le_done !== 1'b1 || le_stall !== 1'b0) begin errors++; $display("FAIL b2b_done: done %b stall %b expected 1 0", le_done, le_stall); end
    @(negedge clk);
    #1;
    checks++; if ({le_done, le_bus_req, le_stall} !== 3'b001) begin errors++; $display("FAIL b2b_idle: done/req/stall got %b expected 001", {le_done, le_bus_req, le_stall}); end
    @(negedge clk);
    op_valid = 1'b0; bus_ack = 1'b1;
    #1;
    checks++; if (le_bus_req !== 1'b1 || le_bus_we !== 1'b1) begin errors++; $display("FAIL b2b_req2: req %b we %b expected 1 1", le_bus_req, le_bus_we); end
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    checks++; if (le_done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b expected 1", le_done); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
